fpm_32_mul: RTL and testbench
=============================

Name: fpm_32_mul

Overview:
- Pipelined IEEE-754 single-precision (binary32) floating-point multiplier.
- Computes m = x * y.
- Sits in the processor datapath as the FP multiply functional unit.
- Accepts a new operand pair every clock; produces the result a fixed number of cycles later.

Parameters:
- None. Format is fixed: 1 sign, 8 exponent (bias 127), 23 fraction bits.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all pipeline registers.
- x  input  32  operand A, binary32.
- y  input  32  operand B, binary32.
- m  output  32  product, binary32; registered output.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset:
  - While rst=1, all pipeline registers and m are 0x00000000, immediately (no clock edge needed).
  - In-flight operations are discarded.
  - After rst falls, m stays 0 until the first post-reset operand pair has traversed the pipeline.
- Pipeline: 3 register stages, latency 3 clk rising edges, throughput 1 op per cycle, no stall or valid handshake.
  - Operands sampled at edge N appear on m after edge N+2.
  - With constant inputs, m is stable from the third edge onward.
- Stage 1, unpack and classify:
  - Extract sign, exponent and fraction of each operand.
  - Classify each operand as zero, normal, inf or NaN.
  - Denormal inputs (exp=0, frac≠0) are treated as zero (flush-to-zero).
- Stage 2, multiply:
  - Sign = sx XOR sy.
  - Exponent sum = ex + ey − 127, held in 10-bit signed.
  - 24x24 → 48-bit unsigned product of the significands, each with the hidden 1.
- Stage 3, normalize, round, pack:
  - If product bit 47 = 1, shift right by 1 and increment the exponent.
  - Round to nearest, ties to even, using guard, round and sticky bits from the discarded low product bits.
  - If rounding carries out of the mantissa, renormalize and increment the exponent.
- Result exponent rules, applied after rounding:
  - exponent ≥ 255 → signed infinity {s, 0xFF, 0}.
  - exponent ≤ 0 → signed zero {s, 31'b0}; no denormal outputs (flush-to-zero).
- Special cases, in priority order:
  1. Either input NaN → 0x7FC00000 (canonical quiet NaN, sign 0).
  2. inf × zero → 0x7FC00000.
  3. inf × (nonzero finite or inf) → signed inf.
  4. zero × finite → signed zero, e.g. −0 × +1 = 0x80000000.
- No exception flag outputs.
- Inputs may change every cycle; each pair is processed independently.

Test Plan:
- Reset: assert rst mid-stream with nonzero operands → m = 0x00000000 immediately. Release rst with x=0x40000000, y=0x40400000 → m = 0x40C00000 (6.0) exactly 3 edges later.
- Normal cases:
  - x=0xBF024510, y=0xBF000000 (−0.5) → m = 0x3E824510.
  - x=0x3FC00000, y=0x3FC00000 (1.5×1.5) → m = 0x40100000 (2.25), which also exercises the bit-47 normalize shift.
- Rounding: x=y=0x3F800001 → m = 0x3F800002; the 2^-46 term is discarded by round-to-nearest.
- Overflow/underflow:
  - 0x7F7FFFFF × 0x40000000 → 0x7F800000.
  - 0x00800000 × 0x3F000000 → 0x00000000 (FTZ).
  - 0x00000001 (denormal) × 0x3F800000 → 0x00000000.
- Specials:
  - 0x7F800000 × 0x00000000 → 0x7FC00000.
  - 0x7FC00001 × 0x3F800000 → 0x7FC00000.
  - 0xFF800000 × 0x40000000 → 0xFF800000.
  - 0x80000000 × 0x3F800000 → 0x80000000.
- Back-to-back throughput: apply 0x40000000×0x40400000, 0x3FC00000×0x3FC00000, 0xBF024510×0xBF000000 on consecutive cycles → m = 0x40C00000, 0x40100000, 0x3E824510 on three consecutive cycles starting 3 edges after the first.

Source files
------------

// File: rtl/fpm_32_mul_if.sv
// Operand/result bundle for the binary32 multiply unit.
// There is no valid/ready handshake: the unit accepts a new x/y pair on every
// rising clk edge and presents the matching product on m three edges later.
interface fpm_32_mul_if;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] m;

    modport master (output x, output y, input m);
    modport slave  (input x, input y, output m);
endinterface

// File: rtl/fpm_32_mul.sv
// Three-stage pipelined binary32 multiplier.
// Stage 1 unpacks and classifies the operands, with denormals flushed to zero.
// Stage 2 forms the sign, the biased exponent sum and the 48-bit significand product.
// Stage 3 normalizes, rounds to nearest-even, applies the exponent limits and
// the special-case overrides, then packs the result.
// Outputs are flushed to zero and there are no exception flags.
module fpm_32_mul (
    input  logic          clk,
    input  logic          rst,
    fpm_32_mul_if.slave   bus
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // ---------------- stage 1: unpack / classify ----------------
    logic        zx, zy, ix, iy, nx, ny;

    assign zx = (bus.x[30:23] == 8'h00);
    assign zy = (bus.y[30:23] == 8'h00);
    assign ix = (bus.x[30:23] == 8'hFF) && (bus.x[22:0] == 23'd0);
    assign iy = (bus.y[30:23] == 8'hFF) && (bus.y[22:0] == 23'd0);
    assign nx = (bus.x[30:23] == 8'hFF) && (bus.x[22:0] != 23'd0);
    assign ny = (bus.y[30:23] == 8'hFF) && (bus.y[22:0] != 23'd0);

    logic        s1_sx, s1_sy;
    logic [7:0]  s1_ex, s1_ey;
    logic [23:0] s1_mx, s1_my;
    logic        s1_zx, s1_zy, s1_ix, s1_iy, s1_nx, s1_ny;

    // Register operand fields and classes; zero-class operands lose their hidden one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sx <= 1'b0;
            s1_sy <= 1'b0;
            s1_ex <= 8'd0;
            s1_ey <= 8'd0;
            s1_mx <= 24'd0;
            s1_my <= 24'd0;
            s1_zx <= 1'b0;
            s1_zy <= 1'b0;
            s1_ix <= 1'b0;
            s1_iy <= 1'b0;
            s1_nx <= 1'b0;
            s1_ny <= 1'b0;
        end else begin
            s1_sx <= bus.x[31];
            s1_sy <= bus.y[31];
            s1_ex <= bus.x[30:23];
            s1_ey <= bus.y[30:23];
            s1_mx <= zx ? 24'd0 : {1'b1, bus.x[22:0]};
            s1_my <= zy ? 24'd0 : {1'b1, bus.y[22:0]};
            s1_zx <= zx;
            s1_zy <= zy;
            s1_ix <= ix;
            s1_iy <= iy;
            s1_nx <= nx;
            s1_ny <= ny;
        end
    end

    // ---------------- stage 2: multiply ----------------
    logic               sign2;
    logic signed [9:0]  exp_sum;
    logic               spec2;
    logic [31:0]        spec_val2;

    assign sign2   = s1_sx ^ s1_sy;
    assign exp_sum = $signed({2'b00, s1_ex}) + $signed({2'b00, s1_ey}) - 10'sd127;

    // Special operand combinations override the arithmetic result, NaN first.
    always_comb begin
        spec2     = 1'b0;
        spec_val2 = 32'd0;
        if (s1_nx || s1_ny) begin
            spec2     = 1'b1;
            spec_val2 = QNAN;
        end else if ((s1_ix && s1_zy) || (s1_iy && s1_zx)) begin
            spec2     = 1'b1;
            spec_val2 = QNAN;
        end else if (s1_ix || s1_iy) begin
            spec2     = 1'b1;
            spec_val2 = {sign2, 8'hFF, 23'd0};
        end else if (s1_zx || s1_zy) begin
            spec2     = 1'b1;
            spec_val2 = {sign2, 31'd0};
        end
    end

    logic               s2_sign;
    logic signed [9:0]  s2_exp;
    logic [47:0]        s2_prod;
    logic               s2_spec;
    logic [31:0]        s2_spec_val;

    // Register the product, exponent sum and any special-case result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_sign     <= 1'b0;
            s2_exp      <= 10'sd0;
            s2_prod     <= 48'd0;
            s2_spec     <= 1'b0;
            s2_spec_val <= 32'd0;
        end else begin
            s2_sign     <= sign2;
            s2_exp      <= exp_sum;
            s2_prod     <= s1_mx * s1_my;
            s2_spec     <= spec2;
            s2_spec_val <= spec_val2;
        end
    end

    // ---------------- stage 3: normalize / round / pack ----------------
    logic [22:0]        frac_t;
    logic               g_bit, r_bit, s_bit, rnd;
    logic signed [10:0] exp_n, exp_f;
    logic [23:0]        frac_r;
    logic [31:0]        res;

    // Select the 23 kept fraction bits, round to nearest-even, then pack or override.
    always_comb begin
        frac_t = 23'd0;
        g_bit  = 1'b0;
        r_bit  = 1'b0;
        s_bit  = 1'b0;
        exp_n  = $signed({s2_exp[9], s2_exp});
        if (s2_prod[47]) begin
            frac_t = s2_prod[46:24];
            g_bit  = s2_prod[23];
            r_bit  = s2_prod[22];
            s_bit  = |s2_prod[21:0];
            exp_n  = $signed({s2_exp[9], s2_exp}) + 11'sd1;
        end else begin
            frac_t = s2_prod[45:23];
            g_bit  = s2_prod[22];
            r_bit  = s2_prod[21];
            s_bit  = |s2_prod[20:0];
        end
        rnd    = g_bit & (r_bit | s_bit | frac_t[0]);
        frac_r = {1'b0, frac_t} + {23'd0, rnd};
        // A carry out of the fraction means 1.111.. rounded up to 10.000..;
        // the kept fraction bits are already zero, only the exponent moves.
        exp_f  = frac_r[23] ? (exp_n + 11'sd1) : exp_n;

        if (s2_spec) begin
            res = s2_spec_val;
        end else if (exp_f >= 11'sd255) begin
            res = {s2_sign, 8'hFF, 23'd0};
        end else if (exp_f <= 11'sd0) begin
            res = {s2_sign, 31'd0};
        end else begin
            res = {s2_sign, exp_f[7:0], frac_r[22:0]};
        end
    end

    // Output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.m <= 32'd0;
        end else begin
            bus.m <= res;
        end
    end

endmodule

// File: tb/tb_fpm_32_mul.sv
// Randomized scoreboard bench for the pipelined binary32 multiplier.
module tb_fpm_32_mul;

    logic clk;
    logic rst;
    logic drv_valid;
    logic [2:0] vpipe;

    int total;
    int bad;

    logic [31:0] exp_q[$];
    logic [63:0] op_q[$];

    fpm_32_mul_if bus ();

    fpm_32_mul dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Exact integer product, rounded to 24 significant bits by remainder
    // comparison against one half ulp, ties to even.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e, msb, sh;
        longint unsigned p, q, rem, half;
        bit za, zb, ia, ib, na, nb;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        if (na || nb) return 32'h7FC00000;
        if ((ia && zb) || (ib && za)) return 32'h7FC00000;
        if (ia || ib) return {s, 8'hFF, 23'd0};
        if (za || zb) return {s, 31'd0};
        p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        msb = 0;
        for (int i = 0; i < 64; i++) if (p[i]) msb = i;
        sh   = msb - 23;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        e = ea + eb - 150 + sh;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], q[22:0]};
    endfunction

    // ---------------- comparison ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] req);
        @(negedge clk);
        bus.x = a;
        bus.y = b;
        drv_valid = 1'b1;
        exp_q.push_back(req);
        op_q.push_back({a, b});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drv_valid = 1'b0;
            bus.x = $urandom;
            bus.y = $urandom;
        end
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0: v[30:23] = 8'h00;
            1: begin
                v[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 0) v[22:0] = 23'd0;
            end
            2: v[30:23] = 8'($urandom_range(1, 10));
            3: v[30:23] = 8'($urandom_range(245, 254));
            default: v[30:23] = 8'($urandom_range(1, 254));
        endcase
        return v;
    endfunction

    task automatic drive_rand(input int n);
        logic [31:0] a, b;
        for (int i = 0; i < n; i++) begin
            a = rand_op();
            b = rand_op();
            drive(a, b, ref_mul(a, b));
        end
    endtask

    // ---------------- monitor ----------------
    // Tracks which cycles carry an issued operation so results are popped in order.
    always @(posedge clk or posedge rst) begin
        if (rst) vpipe <= 3'b000;
        else     vpipe <= {vpipe[1:0], drv_valid};
    end

    // Pop one expected product for every issued operation that reaches m.
    always @(negedge clk) begin
        logic [63:0] op;
        if (!rst && vpipe[2]) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL result_without_issue: got %08h expected none", bus.m);
            end else begin
                op = op_q.pop_front();
                check($sformatf("mul %08h*%08h", op[63:32], op[31:0]), bus.m, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] dir_x[11];
    logic [31:0] dir_y[11];
    logic [31:0] dir_m[11];

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        drv_valid = 1'b0;
        bus.x = 32'h3F800000;
        bus.y = 32'h40000000;

        dir_x = '{32'h40000000, 32'h3FC00000, 32'hBF024510, 32'h3F800001, 32'h7F7FFFFF,
                  32'h00800000, 32'h00000001, 32'h7F800000, 32'h7FC00001, 32'hFF800000,
                  32'h80000000};
        dir_y = '{32'h40400000, 32'h3FC00000, 32'hBF000000, 32'h3F800001, 32'h40000000,
                  32'h3F000000, 32'h3F800000, 32'h00000000, 32'h3F800000, 32'h40000000,
                  32'h3F800000};
        dir_m = '{32'h40C00000, 32'h40100000, 32'h3E824510, 32'h3F800002, 32'h7F800000,
                  32'h00000000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000,
                  32'h80000000};

        // Power-up reset with clocks running.
        repeat (3) @(posedge clk);
        #1 check("reset_m", bus.m, 32'h0);

        // Release reset with 2.0*3.0 presented; m holds 0 for two edges.
        @(negedge clk);
        rst = 1'b0;
        bus.x = 32'h40000000;
        bus.y = 32'h40400000;
        drv_valid = 1'b1;
        exp_q.push_back(32'h40C00000);
        op_q.push_back({32'h40000000, 32'h40400000});
        @(negedge clk);
        drv_valid = 1'b0;
        check("post_reset_edge1", bus.m, 32'h0);
        @(posedge clk);
        #1 check("post_reset_edge2", bus.m, 32'h0);
        idle(3);

        // Directed vectors back to back; the first three form the throughput case.
        for (int i = 0; i < 11; i++) drive(dir_x[i], dir_y[i], dir_m[i]);
        idle(4);

        // Random traffic.
        drive_rand(300);

        // Reset mid-stream: m must clear without a clock edge and in-flight work is dropped.
        @(negedge clk);
        #2 rst = 1'b1;
        drv_valid = 1'b0;
        #1 check("midstream_reset_m", bus.m, 32'h0);
        exp_q.delete();
        op_q.delete();
        @(posedge clk);
        #1 check("reset_held_m", bus.m, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        check("after_reset_idle_m", bus.m, 32'h0);

        drive_rand(300);
        idle(6);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
